// File: rtl/axi_pkg.sv
// axi_pkg: shared AXI burst/size codes, read-master state enum and AR/R field widths
package axi_pkg;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] SIZE_1B = 2'b00;
  localparam logic [1:0] SIZE_2B = 2'b01;
  localparam logic [1:0] SIZE_4B = 2'b10;
  localparam int AR_LEN_W   = 4;
  localparam int AR_SIZE_W  = 2;
  localparam int AR_BURST_W = 2;
  localparam int AR_LOCK_W  = 2;
  localparam int AR_CACHE_W = 4;
  localparam int AR_PROT_W  = 3;
  localparam int RESP_W     = 2;
  typedef enum logic [1:0] {RM_IDLE, RM_ADDR, RM_DATA} rm_state_e;
endpackage

// File: rtl/axi_read_master_if.sv
// axi_read_master_if: AXI AR + R channel bundle between read master and read slave
//   master modport drives AR payload/ARVALID and RREADY; slave modport drives ARREADY and R beat
interface axi_read_master_if
  import axi_pkg::*;
#(parameter int BusWidth = 32, parameter int tagbits = 2);
  logic [tagbits-1:0]    ARID;
  logic [BusWidth-1:0]   ARADDR;
  logic [AR_LEN_W-1:0]   ARLEN;
  logic [AR_SIZE_W-1:0]  ARSIZE;
  logic [AR_BURST_W-1:0] ARBURST;
  logic [AR_LOCK_W-1:0]  ARLOCK;
  logic [AR_CACHE_W-1:0] ARCACHE;
  logic [AR_PROT_W-1:0]  ARPROT;
  logic                  ARVALID;
  logic                  ARREADY;
  logic [tagbits-1:0]    RID;
  logic [BusWidth-1:0]   RDATA;
  logic [RESP_W-1:0]     RRESP;
  logic                  RLAST;
  logic                  RVALID;
  logic                  RREADY;
  modport master (
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT, ARVALID, RREADY,
    input  ARREADY, RID, RDATA, RRESP, RLAST, RVALID
  );
  modport slave (
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT, ARVALID, RREADY,
    output ARREADY, RID, RDATA, RRESP, RLAST, RVALID
  );
endinterface

// File: rtl/axi_pipe_reg.sv
// axi_pipe_reg: one-entry valid/ready register; accepts a new word while draining the held one
//   ACLK/ARESETn; in_valid/in_ready/in_data upstream; out_valid/out_ready/out_data downstream
module axi_pipe_reg #(parameter int W = 8) (
  input  logic         ACLK,
  input  logic         ARESETn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  assign in_ready = !out_valid || out_ready;
  always_ff @(posedge ACLK or negedge ARESETn)
    if (!ARESETn) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_valid && in_ready) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
    end else if (out_ready) out_valid <= 1'b0;
endmodule

// File: rtl/axi_read_master.sv
// axi_read_master: single-outstanding AXI read initiator (AR issue, R collect, one-entry beat register)
//   ACLK/ARESETn (async, active-low); client request req_*; AR/R via axi (master modport);
//   client beat rd_*; busy from accept to final capture; sticky err_rid/err_rlast
//   Build option READ_MASTER_PROTOCOL_CHECK_EN: RID/RLAST checking and count-based burst end;
//   without it the errors read 0 and RLAST alone ends the burst
module axi_read_master
  import axi_pkg::*;
#(parameter int BusWidth = 32, parameter int tagbits = 2) (
  input  logic                ACLK,
  input  logic                ARESETn,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [tagbits-1:0]  req_id,
  input  logic [BusWidth-1:0] req_addr,
  input  logic [1:0]          req_len,
  input  logic [1:0]          req_size,
  input  logic [1:0]          req_burst,
  axi_read_master_if.master   axi,
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic [tagbits-1:0]  rd_id,
  output logic [BusWidth-1:0] rd_data,
  output logic [RESP_W-1:0]   rd_resp,
  output logic                rd_last,
  output logic                busy,
  output logic                err_rid,
  output logic                err_rlast
);
  localparam int BeatW = tagbits + BusWidth + RESP_W + 1;
  rm_state_e  state;
  logic [2:0] beat_cnt;
  logic       accept, r_fire, fin, pipe_in_ready;
  assign accept      = state == RM_IDLE && req_valid && req_ready;
  assign axi.RREADY  = state == RM_DATA && pipe_in_ready;
  assign r_fire      = axi.RVALID && axi.RREADY;
  assign axi.ARLOCK  = '0;
  assign axi.ARCACHE = '0;
  assign axi.ARPROT  = '0;
`ifdef READ_MASTER_PROTOCOL_CHECK_EN
  logic cnt_hit;
  assign cnt_hit = beat_cnt == {1'b0, axi.ARLEN[1:0]};
  assign fin     = axi.RLAST || cnt_hit;
  always_ff @(posedge ACLK or negedge ARESETn)
    if (!ARESETn) begin
      err_rid   <= 1'b0;
      err_rlast <= 1'b0;
    end else if (accept) begin
      err_rid   <= 1'b0;
      err_rlast <= 1'b0;
    end else if (r_fire) begin
      if (axi.RID != axi.ARID) err_rid <= 1'b1;
      if (axi.RLAST != cnt_hit) err_rlast <= 1'b1;
    end
`else
  assign fin       = axi.RLAST;
  assign err_rid   = 1'b0;
  assign err_rlast = 1'b0;
`endif
  always_ff @(posedge ACLK or negedge ARESETn)
    if (!ARESETn) begin
      state       <= RM_IDLE;
      req_ready   <= 1'b0;
      busy        <= 1'b0;
      beat_cnt    <= '0;
      axi.ARVALID <= 1'b0;
      axi.ARID    <= '0;
      axi.ARADDR  <= '0;
      axi.ARLEN   <= '0;
      axi.ARSIZE  <= '0;
      axi.ARBURST <= '0;
    end else case (state)
      RM_IDLE:
        if (accept) begin
          state       <= RM_ADDR;
          req_ready   <= 1'b0;
          busy        <= 1'b1;
          beat_cnt    <= '0;
          axi.ARVALID <= 1'b1;
          axi.ARID    <= req_id;
          axi.ARADDR  <= req_addr;
          axi.ARLEN   <= {2'b00, req_len};
          axi.ARSIZE  <= req_size == 2'b11 ? SIZE_4B : req_size;
          axi.ARBURST <= req_burst == 2'b11 ? BURST_INCR : req_burst;
        end else req_ready <= 1'b1;
      RM_ADDR:
        if (axi.ARREADY) begin
          state       <= RM_DATA;
          axi.ARVALID <= 1'b0;
        end
      RM_DATA:
        if (r_fire) begin
          beat_cnt <= beat_cnt + 3'd1;
          if (fin) begin
            state     <= RM_IDLE;
            busy      <= 1'b0;
            req_ready <= 1'b1;
          end
        end
      default: state <= RM_IDLE;
    endcase
  axi_pipe_reg #(.W(BeatW)) u_pipe (
    .ACLK      (ACLK),
    .ARESETn   (ARESETn),
    .in_valid  (state == RM_DATA && axi.RVALID),
    .in_ready  (pipe_in_ready),
    .in_data   ({axi.RID, axi.RDATA, axi.RRESP, axi.RLAST}),
    .out_valid (rd_valid),
    .out_ready (rd_ready),
    .out_data  ({rd_id, rd_data, rd_resp, rd_last})
  );
endmodule

// File: doc/axi_read_master.md
# axi_read_master

Initiator side of the project's AXI read channels. It accepts one burst request at a time from a local client and drives the AR channel. It collects the R beats and hands each beat to the client through a one-entry output register. It connects directly to the AR/R ports of the read slave and issues only what that slave supports: up to 4 beats, sizes of 1/2/4 bytes, and FIXED/INCR/WRAP burst codes.

## Interface
- BusWidth, 32, address and data width
- tagbits, 2, ID width (2 masters × 2 IDs)
- ACLK  in  1  global clock; all state changes on the rising edge
- ARESETn  in  1  asynchronous, active-low reset
- req_valid  in  1  client burst request valid
- req_ready  out  1  request accepted when req_valid & req_ready
- req_id  in  tagbits  transaction ID
- req_addr  in  BusWidth  start address
- req_len  in  2  beats − 1 (0..3)
- req_size  in  2  00 = 1 B, 01 = 2 B, 10 = 4 B; 11 is issued as 10
- req_burst  in  2  00 FIXED, 01 INCR, 10 WRAP; 11 is issued as 01
- ARID/ARADDR/ARLEN/ARSIZE/ARBURST  out  tagbits/BusWidth/4/2/2  AR payload
- ARLOCK/ARCACHE/ARPROT  out  2/4/3  constant 0
- ARVALID  out  1; ARREADY  in  1
- RID  in  tagbits; RDATA  in  BusWidth; RRESP  in  2; RLAST  in  1; RVALID  in  1
- RREADY  out  1
- rd_valid  out  1  client beat valid
- rd_ready  in  1  client accepts beat
- rd_id/rd_data/rd_resp/rd_last  out  tagbits/BusWidth/2/1  captured beat
- busy  out  1  high from request accept until the final beat is captured
- err_rid  out  1  sticky; RID ≠ issued ID
- err_rlast  out  1  sticky; RLAST disagrees with the beat count

## Operation
- FSM states: IDLE, ADDR, DATA.
- IDLE
  - req_ready = 1.
  - On req_valid: latch the request into the AR registers, set ARLEN = {2'b00, req_len}, load beat_cnt = 0, clear err_rid and err_rlast, set busy, go to ADDR.
- ADDR
  - ARVALID = 1, with the payload held stable.
  - On ARVALID & ARREADY: go to DATA.
  - ARREADY may toggle while ARVALID is high. This is legal; only the handshake edge matters.
- DATA
  - RREADY = !rd_valid | rd_ready.
  - On RVALID & RREADY: capture RID/RDATA/RRESP/RLAST into the rd_* outputs, set rd_valid, increment beat_cnt (3 bits, no wrap for len ≤ 3).
  - The final beat is the one where RLAST = 1 or beat_cnt == ARLEN[1:0]. On the final beat: go to IDLE and clear busy.
- Output register
  - rd_valid clears on rd_ready when no new beat is captured in the same cycle.
  - A simultaneous capture and drain keeps rd_valid = 1 and loads the new beat.
- A new request may be accepted in IDLE while rd_valid still holds the previous final beat.
- RRESP is passed through only; it is never interpreted.
- RVALID seen in IDLE or ADDR is ignored and RREADY stays 0 in those states.
- Reset mid-burst discards the transaction. No beat is delivered afterwards.

## Timing
- Reset values: req_ready 0 (1 from the first cycle after reset), ARVALID 0, all AR payload 0, RREADY 0, rd_valid 0, rd_* 0, busy 0, err_* 0.
- Request accepted at edge N gives ARVALID = 1 from N+1.
- AR handshake at edge M: RREADY may be 1 from M+1.
- Beat captured at edge K: rd_valid = 1 from K+1.
- Minimum request-to-first-beat-on-rd: 3 cycles, given ARREADY and RVALID both high when sampled.
- Full throughput: 1 beat per cycle while rd_ready = 1.
- rd_ready = 0 stalls R via RREADY the cycle after a beat is held.

## Configuration
- READ_MASTER_PROTOCOL_CHECK_EN defined:
  - A captured beat with RID ≠ ARID sets err_rid.
  - A beat with RLAST = 1 and beat_cnt ≠ ARLEN[1:0], or beat_cnt == ARLEN[1:0] with RLAST = 0, sets err_rlast.
  - The transaction ends at the first of the two conditions.
- Not defined:
  - err_rid and err_rlast are tied to 0.
  - The final beat is determined by RLAST alone. beat_cnt is still maintained.

## Structure
- Shared package axi_pkg holds:
  - BURST_FIXED/INCR/WRAP
  - SIZE_1B/2B/4B
  - the read-master state enum
  - the AR payload field-width localparams shared with the read slave
- One sub-module, axi_pipe_reg: a one-entry valid/ready register holding {id, data, resp, last}, instantiated for the R → rd path.

## Test plan
- Single beat: req_id=2, req_addr=0x100, req_len=0, req_size=10, req_burst=00; ARREADY=1; slave returns RDATA=0xDEADBEEF, RLAST=1 → ARLEN=0, ARSIZE=10; one rd beat with data 0xDEADBEEF, rd_last=1, rd_id=2; busy low after capture; no errors.
- 4-beat INCR at 0x200 with ARREADY held low for 3 cycles → ARVALID and payload stable for 4 cycles; 4 rd beats delivered in order, last one flagged.
- Backpressure: rd_ready=0 for 5 cycles mid-burst → RREADY drops one cycle after the held beat; no beat lost or duplicated.
- With the macro defined:
  - RID=1 while ARID=3 → err_rid=1 and stays 1 until the next request accept.
  - RLAST on beat 2 of a len=3 burst → err_rlast=1, FSM returns to IDLE.
- ARESETn low during DATA after beat 1 → all outputs at reset values. The next request completes normally.
